// File: rtl/yl3_scan_if.sv
// yl3_scan_if: host load port plus 74HC595 serial pins of the 8-digit scan driver.
interface yl3_scan_if;
  logic [63:0] data;
  logic        load;
  logic        ready;
  logic        sck;
  logic        rck;
  logic        dio;

  modport master (output data, load, input ready, sck, rck, dio);
  modport slave  (input data, load, output ready, sck, rck, dio);
endinterface

// File: rtl/yl3_scan_driver.sv
// yl3_scan_driver: multiplexes an 8-digit seven-segment display through a pair
// of 74HC595s, one 16-bit {seg, sel} frame per digit, continuously.
// Optional macro YL3_DECODE_EN: treat each display byte as ASCII and decode it
// to an active-low segment pattern; without it the byte is sent as-is.
module yl3_scan_driver #(
  parameter int unsigned SCK_DIV     = 4,
  parameter int unsigned HOLD_CYCLES = 6250
) (
  input logic       clk,
  input logic       rst,
  yl3_scan_if.slave bus
);

  localparam int unsigned CNT_MAX = (HOLD_CYCLES > SCK_DIV) ? HOLD_CYCLES : SCK_DIV;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
`ifdef YL3_DECODE_EN
  localparam logic [63:0] BLANK = 64'h2020_2020_2020_2020;
`else
  localparam logic [63:0] BLANK = 64'hFFFF_FFFF_FFFF_FFFF;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, HOLD} state_t;

`ifdef YL3_DECODE_EN
  // ASCII to active-low {dp,g,f,e,d,c,b,a}; letters share one glyph per case pair.
  function automatic logic [7:0] seg_of(input logic [7:0] c);
    logic [7:0] u;
    u = (c >= 8'h61 && c <= 8'h7A) ? (c - 8'h20) : c;
    case (u)
      8'h20: seg_of = 8'hFF;
      8'h30: seg_of = 8'hC0;  8'h31: seg_of = 8'hF9;  8'h32: seg_of = 8'hA4;
      8'h33: seg_of = 8'hB0;  8'h34: seg_of = 8'h99;  8'h35: seg_of = 8'h92;
      8'h36: seg_of = 8'h82;  8'h37: seg_of = 8'hF8;  8'h38: seg_of = 8'h80;
      8'h39: seg_of = 8'h90;
      8'h41: seg_of = 8'h88;  8'h42: seg_of = 8'h83;  8'h43: seg_of = 8'hC6;
      8'h44: seg_of = 8'hA1;  8'h45: seg_of = 8'h86;  8'h46: seg_of = 8'h8E;
      8'h47: seg_of = 8'hC2;  8'h48: seg_of = 8'h89;  8'h49: seg_of = 8'hF9;
      8'h4A: seg_of = 8'hE1;  8'h4B: seg_of = 8'h8A;  8'h4C: seg_of = 8'hC7;
      8'h4D: seg_of = 8'hC8;  8'h4E: seg_of = 8'hAB;  8'h4F: seg_of = 8'hC0;
      8'h50: seg_of = 8'h8C;  8'h51: seg_of = 8'h98;  8'h52: seg_of = 8'hAF;
      8'h53: seg_of = 8'h92;  8'h54: seg_of = 8'h87;  8'h55: seg_of = 8'hC1;
      8'h56: seg_of = 8'hE3;  8'h57: seg_of = 8'h81;  8'h58: seg_of = 8'hB6;
      8'h59: seg_of = 8'h91;  8'h5A: seg_of = 8'hA4;
      default: seg_of = 8'hBF;
    endcase
  endfunction
`else
  // Raw mode: the display byte already is the segment pattern.
  function automatic logic [7:0] seg_of(input logic [7:0] c);
    seg_of = c;
  endfunction
`endif

  state_t             state;
  logic [63:0]        disp;
  logic [2:0]         idx;
  logic [15:0]        frame_sr;
  logic [3:0]         bit_cnt;
  logic               phase;
  logic [CNT_W-1:0]   cnt;
  logic               sck_q, rck_q, dio_q, ready_q;

  logic               accept_c;
  logic [63:0]        disp_next_c;
  logic [5:0]         lsb_c;
  logic [15:0]        frame_c;

  // A capture on the same edge as frame start is bypassed into that frame.
  always_comb begin
    accept_c    = bus.load & ready_q;
    disp_next_c = accept_c ? bus.data : disp;
    lsb_c       = {3'd7 - idx, 3'b000};
    frame_c     = {seg_of(disp_next_c[lsb_c +: 8]), 8'h80 >> idx};
  end

  // Scan FSM: shift the frame, latch it, hold the digit lit, next digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      disp     <= BLANK;
      idx      <= 3'd0;
      frame_sr <= 16'd0;
      bit_cnt  <= 4'd0;
      phase    <= 1'b0;
      cnt      <= '0;
      sck_q    <= 1'b0;
      rck_q    <= 1'b0;
      dio_q    <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      if (accept_c) disp <= bus.data;
      case (state)
        IDLE: begin
          if (!ready_q) begin
            ready_q <= 1'b1;
          end else begin
            state    <= SHIFT;
            ready_q  <= 1'b0;
            frame_sr <= frame_c;
            dio_q    <= frame_c[15];
            sck_q    <= 1'b0;
            bit_cnt  <= 4'd0;
            phase    <= 1'b0;
            cnt      <= '0;
          end
        end
        SHIFT: begin
          if (cnt == CNT_W'(SCK_DIV - 1)) begin
            cnt <= '0;
            if (!phase) begin
              phase <= 1'b1;
              sck_q <= 1'b1;
            end else begin
              phase <= 1'b0;
              sck_q <= 1'b0;
              if (bit_cnt == 4'd15) begin
                state <= LATCH;
                rck_q <= 1'b1;
                dio_q <= 1'b0;
              end else begin
                bit_cnt  <= bit_cnt + 4'd1;
                frame_sr <= frame_sr << 1;
                dio_q    <= frame_sr[14];
              end
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        LATCH: begin
          if (cnt == CNT_W'(SCK_DIV - 1)) begin
            cnt     <= '0;
            rck_q   <= 1'b0;
            ready_q <= 1'b1;
            idx     <= idx + 3'd1;
            state   <= HOLD;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HOLD: begin
          if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
            state    <= SHIFT;
            ready_q  <= 1'b0;
            frame_sr <= frame_c;
            dio_q    <= frame_c[15];
            bit_cnt  <= 4'd0;
            phase    <= 1'b0;
            cnt      <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready = ready_q;
  assign bus.sck   = sck_q;
  assign bus.rck   = rck_q;
  assign bus.dio   = dio_q;

endmodule

// File: tb/tb_yl3_scan_driver.sv
// tb_yl3_scan_driver: frame-level scoreboard for the 74HC595 scan driver.
module tb_yl3_scan_driver;

  localparam int unsigned SCK_DIV = 2;
  localparam int unsigned HOLD    = 4;
  localparam int          PERIOD  = 33 * SCK_DIV + HOLD;
`ifdef YL3_DECODE_EN
  localparam logic [63:0] BLANK = 64'h2020_2020_2020_2020;
`else
  localparam logic [63:0] BLANK = 64'hFFFF_FFFF_FFFF_FFFF;
`endif

  typedef struct {
    logic [15:0] bits;
    int          nbits;
    int          rck_len;
    int          start;
  } frame_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  yl3_scan_if bus();

  yl3_scan_driver #(.SCK_DIV(SCK_DIV), .HOLD_CYCLES(HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  frame_t      act_q[$];
  logic [15:0] exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          rck_pulses = 0;
  int          mon_nbits = 0;
  logic [7:0]  glyph [256];
  logic [63:0] m_disp;
  int          m_idx = 0;
  int          last_start = 0;
  bit          have_last = 0;

  // Expected glyphs, built from per-class tables.
  initial begin
    logic [7:0] dig_tbl [10];
    logic [7:0] up_tbl [26];
    dig_tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    up_tbl  = '{8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E, 8'hC2, 8'h89, 8'hF9, 8'hE1,
                8'h8A, 8'hC7, 8'hC8, 8'hAB, 8'hC0, 8'h8C, 8'h98, 8'hAF, 8'h92, 8'h87,
                8'hC1, 8'hE3, 8'h81, 8'hB6, 8'h91, 8'hA4};
    for (int i = 0; i < 256; i++) glyph[i] = 8'hBF;
    glyph[8'h20] = 8'hFF;
    for (int i = 0; i < 10; i++) glyph[8'(8'h30 + i)] = dig_tbl[i];
    for (int i = 0; i < 26; i++) begin
      glyph[8'(8'h41 + i)] = up_tbl[i];
      glyph[8'(8'h61 + i)] = up_tbl[i];
    end
  end

  function automatic logic [7:0] m_seg(input logic [7:0] b);
`ifdef YL3_DECODE_EN
    return glyph[b];
`else
    return b;
`endif
  endfunction

  function automatic logic [15:0] m_frame(input logic [63:0] d, input int k);
    logic [7:0] b;
    logic [7:0] sel;
    b   = d[63 - 8 * k -: 8];
    sel = 8'h80 >> k;
    return {m_seg(b), sel};
  endfunction

  // Pin monitor: reassemble frames from SCK rising edges, time RCK and frame starts.
  initial begin
    logic [15:0] shreg;
    logic        psck, prck, pready;
    int          rlen, cur_start;
    frame_t      f;
    shreg = 16'd0; psck = 0; prck = 0; pready = 0; rlen = 0; cur_start = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        mon_nbits = 0; rlen = 0; psck = 0; prck = 0; pready = 0;
        act_q.delete();
      end else begin
        if (pready && !bus.ready) begin
          cur_start = cyc; mon_nbits = 0; rlen = 0;
        end
        if (bus.sck && !psck) begin
          shreg = {shreg[14:0], bus.dio};
          mon_nbits++;
        end
        if (bus.rck) rlen++;
        if (bus.rck && !prck) rck_pulses++;
        if (!bus.rck && prck) begin
          f.bits = shreg; f.nbits = mon_nbits; f.rck_len = rlen; f.start = cur_start;
          act_q.push_back(f);
        end
        psck = bus.sck; prck = bus.rck; pready = bus.ready;
      end
    end
  end

  // Predict n frames from the model, then compare each against the monitor.
  task automatic check_frames(input int n);
    frame_t      f;
    logic [15:0] e;
    int          k;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(m_frame(m_disp, m_idx));
      m_idx = (m_idx + 1) % 8;
      k = 0;
      while (act_q.size() == 0 && k < 200) begin
        @(posedge clk);
        k++;
      end
      #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (act_q.size() == 0) begin
        n_bad++;
        $display("FAIL frame_timeout: no frame within 200 cycles, required %h", e);
        return;
      end
      f = act_q.pop_front();
      if (f.bits !== e || f.nbits != 16) begin
        n_bad++;
        $display("FAIL frame: got %h (%0d bits) required %h (16 bits)", f.bits, f.nbits, e);
      end
      n_cmp++;
      if (f.rck_len != int'(SCK_DIV)) begin
        n_bad++;
        $display("FAIL rck_len: got %0d required %0d", f.rck_len, SCK_DIV);
      end
      if (have_last) begin
        n_cmp++;
        if (f.start - last_start != PERIOD) begin
          n_bad++;
          $display("FAIL period: got %0d required %0d", f.start - last_start, PERIOD);
        end
      end
      last_start = f.start;
      have_last  = 1;
    end
  endtask

  task automatic test_reset();
    bus.data = 64'd0;
    bus.load = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.sck !== 1'b0)   begin n_bad++; $display("FAIL rst_sck: got %b required 0", bus.sck); end
    n_cmp++; if (bus.rck !== 1'b0)   begin n_bad++; $display("FAIL rst_rck: got %b required 0", bus.rck); end
    n_cmp++; if (bus.dio !== 1'b0)   begin n_bad++; $display("FAIL rst_dio: got %b required 0", bus.dio); end
    n_cmp++; if (bus.ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b required 0", bus.ready); end
    @(negedge clk); #1;
    rst = 1'b0;
    m_disp = BLANK; m_idx = 0; have_last = 0;
    @(posedge clk); #1;
    n_cmp++; if (bus.ready !== 1'b1) begin n_bad++; $display("FAIL idle_ready: got %b required 1", bus.ready); end
    n_cmp++; if (bus.sck !== 1'b0)   begin n_bad++; $display("FAIL idle_sck: got %b required 0", bus.sck); end
  endtask

  task automatic test_scan_wrap();
    check_frames(9);
  endtask

  task automatic test_load_hold();
    n_cmp++;
    if (bus.ready !== 1'b1) begin n_bad++; $display("FAIL hold_ready: got %b required 1", bus.ready); end
    bus.data = 64'h2020_2048_454C_4C4F;
    bus.load = 1'b1;
    m_disp   = 64'h2020_2048_454C_4C4F;
    @(posedge clk); #1;
    bus.load = 1'b0;
    check_frames(8);
  endtask

  task automatic test_load_shift();
    int k;
    k = 0;
    while (bus.ready !== 1'b0 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    n_cmp++;
    if (bus.ready !== 1'b0) begin n_bad++; $display("FAIL shift_ready: got %b required 0", bus.ready); end
    bus.data = 64'h0123_4567_89AB_CDEF;
    bus.load = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    bus.load = 1'b0;
    check_frames(3);
  endtask

  task automatic test_raw_byte();
    bus.data = 64'h5A31_3233_3435_3637;
    bus.load = 1'b1;
    m_disp   = 64'h5A31_3233_3435_3637;
    @(posedge clk); #1;
    bus.load = 1'b0;
    check_frames(8);
  endtask

  task automatic test_reset_midframe();
    int k;
    int pulses0;
    k = 0;
    while (!(mon_nbits == 7 && bus.ready === 1'b0) && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    n_cmp++;
    if (mon_nbits != 7) begin n_bad++; $display("FAIL bit7_wait: got %0d bits required 7", mon_nbits); end
    pulses0 = rck_pulses;
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.sck !== 1'b0)   begin n_bad++; $display("FAIL abort_sck: got %b required 0", bus.sck); end
    n_cmp++; if (bus.rck !== 1'b0)   begin n_bad++; $display("FAIL abort_rck: got %b required 0", bus.rck); end
    n_cmp++; if (bus.dio !== 1'b0)   begin n_bad++; $display("FAIL abort_dio: got %b required 0", bus.dio); end
    n_cmp++; if (bus.ready !== 1'b0) begin n_bad++; $display("FAIL abort_ready: got %b required 0", bus.ready); end
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if (rck_pulses != pulses0) begin n_bad++; $display("FAIL abort_rck_pulse: got %0d pulses required %0d", rck_pulses, pulses0); end
    m_disp = BLANK; m_idx = 0; have_last = 0;
    @(posedge clk); #1;
    n_cmp++; if (bus.ready !== 1'b1) begin n_bad++; $display("FAIL restart_ready: got %b required 1", bus.ready); end
    check_frames(2);
  endtask

  initial begin
    test_reset();
    test_scan_wrap();
    test_load_hold();
    test_load_shift();
    test_raw_byte();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/yl3_scan_driver.md
YL3_SCAN_DRIVER -- requirements
Module: yl3_scan_driver

Interface
REQ-001 The block SHALL have parameter SCK_DIV, default 4, giving the SCK half-period in CLK cycles (legal range >=1).
REQ-002 The block SHALL have parameter HOLD_CYCLES, default 6250, giving the idle CLK cycles between digit frames (legal range >=1).
REQ-003 CLK  input  1  system clock; all logic is on the rising edge.
REQ-004 RST  input  1  reset, asynchronous and active-high.
REQ-005 DATA  input  64  eight display bytes; DATA[63:56] is digit 0 (leftmost) and DATA[7:0] is digit 7.
REQ-006 LOAD  input  1  capture request, qualified by READY.
REQ-007 READY  output  1  high when a LOAD is accepted.
REQ-008 SCK  output  1  74HC595 shift clock.
REQ-009 RCK  output  1  74HC595 latch clock.
REQ-010 DIO  output  1  74HC595 serial data.

Function
REQ-011 The FSM SHALL have states IDLE, SHIFT, LATCH and HOLD; transitions are IDLE->SHIFT after 1 cycle, SHIFT->LATCH after 16 bits, LATCH->HOLD after SCK_DIV cycles, and HOLD->SHIFT after HOLD_CYCLES cycles.
REQ-012 READY SHALL be 1 in IDLE and HOLD and 0 in SHIFT and LATCH.
REQ-013 LOAD=1 with READY=1 at a rising edge SHALL copy DATA into the 64-bit display register; LOAD with READY=0 SHALL be ignored, with no queuing.
REQ-014 On entry to SHIFT, the block SHALL build a 16-bit frame {seg[7:0], sel[7:0]} from the display register byte at the digit index; it is sent MSB first, so the segment byte goes first.
REQ-015 sel SHALL be one-hot and active-high, equal to 8'h80 >> index, so digit 0 gives 8'h80.
REQ-016 seg SHALL be active-low with bit order {dp,g,f,e,d,c,b,a}.
REQ-017 Each bit SHALL take 2*SCK_DIV cycles: DIO is updated at the start of the SCK-low phase, SCK is low for SCK_DIV cycles and then high for SCK_DIV cycles, and the slave samples on the rising edge.
REQ-018 In LATCH, SCK SHALL be 0 and RCK SHALL be 1 for SCK_DIV cycles; otherwise RCK SHALL be 0.
REQ-019 The digit index SHALL increment on LATCH->HOLD and wrap from 7 to 0; LOAD SHALL NOT reset the index.
REQ-020 A frame SHALL use the display register contents sampled at SHIFT entry, so a capture during HOLD takes effect from the next frame with no tearing.
REQ-021 Frame period SHALL be exactly 33*SCK_DIV + HOLD_CYCLES cycles.
REQ-022 In HOLD, SCK, RCK and DIO SHALL all be 0.

Reset
REQ-023 While RST=1, SCK, RCK, DIO and READY SHALL all be 0, the FSM SHALL be in IDLE and the digit index SHALL be 0.
REQ-024 While RST=1, the display register SHALL be blank: 64'h2020202020202020 when decode is compiled in, 64'hFFFFFFFFFFFFFFFF otherwise.
REQ-025 Assertion of RST mid-frame SHALL abort the frame immediately without pulsing RCK.
REQ-026 In the first cycle after RST deasserts, the block SHALL be in IDLE with READY=1.

Configuration
REQ-027 With YL3_DECODE_EN defined, each display byte SHALL be treated as ASCII and decoded to seg: '0'..'9' standard (for example '0'=8'hC0), 'A'..'Z' and 'a'..'z' mapped to the team glyph table ('H'=8'h89), ' '=8'hFF, and any other code giving 8'hBF (dash).
REQ-028 Without YL3_DECODE_EN, each display byte SHALL be sent unmodified as seg, and no decoder logic SHALL be synthesized.

Verification (SCK_DIV=2, HOLD_CYCLES=4, YL3_DECODE_EN defined unless noted)
REQ-029 Release RST with no LOAD -> the first frame shifts 16'hFF80, RCK is high for 2 cycles, and the next frame starts 70 cycles after the first.
REQ-030 LOAD with DATA="   HELLO" during HOLD -> READY=1 at capture, the next frame uses the new data, and the frame for index 3 shifts 16'h8910.
REQ-031 LOAD pulsed during SHIFT -> the display register is unchanged and frame contents are unchanged.
REQ-032 Run 9 frames -> sel sequence is 80,40,20,10,08,04,02,01,80.
REQ-033 Assert RST at bit 7 of a frame -> SCK, RCK, DIO and READY are 0 within the same cycle, no RCK pulse occurs, and after release scanning restarts at digit 0 with a blank display.
REQ-034 Build without YL3_DECODE_EN and load DATA byte 8'h5A at digit 0 -> the frame shifts 16'h5A80.
